fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the ASYNC_FIFO write port among NUM_REQ requesters in the wclk domain.
//  Each requester presents data with a valid/ready handshake; the granted stream drives winc/wData directly.
//  The grant is held for a bounded burst, then released so the next requester is served.
//  Sits between write-side producers and ASYNC_FIFO (winc, wData, wFull).
// PARAMETERS
//  NUM_REQ    4   number of requesters, 2..8
//  DATA_SIZE  12  data width; must equal ASYNC_FIFO DATA_SIZE
//  MAX_BURST  4   max words transferred per grant, 1..16
// PORTS
//  wclk        in   1                    write-domain clock; all logic on rising edge
//  wrst        in   1                    asynchronous, active-low reset
//  req_valid   in   NUM_REQ              per-requester data valid
//  req_data    in   NUM_REQ*DATA_SIZE    packed data; requester i at [i*DATA_SIZE +: DATA_SIZE]
//  req_ready   out  NUM_REQ              per-requester accept (combinational)
//  winc        out  1                    FIFO write strobe (to ASYNC_FIFO winc)
//  wData       out  DATA_SIZE            FIFO write data (to ASYNC_FIFO wData)
//  wFull       in   1                    FIFO full flag (from ASYNC_FIFO wFull)
//  grant_id    out  $clog2(NUM_REQ)      index of the current/last granted requester (registered)
//  busy        out  1                    1 while state==GRANT (registered)
// BEHAVIOUR
//  Reset (wrst=0, async): state=IDLE, rr_ptr=NUM_REQ-1, burst_cnt=0, grant_id=0, busy=0.
//   Combinational outputs then evaluate to winc=0, req_ready=0, wData=0.
//  FSM with two states:
//   IDLE:  if |req_valid, select the first valid index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
//          Next state GRANT; grant_id=sel; rr_ptr=sel; burst_cnt=0. wFull does not block the grant.
//   GRANT: req_ready[grant_id] = !wFull; all other req_ready = 0.
//          xfer = req_valid[grant_id] & req_ready[grant_id]; winc = xfer (zero latency).
//          wData = req_data[grant_id] while in GRANT; 0 otherwise.
//          On xfer: burst_cnt++. If burst_cnt==MAX_BURST-1, go to IDLE.
//          If req_valid[grant_id]==0, go to IDLE (no transfer that cycle).
//          If req_valid & wFull: stall; hold grant, burst_cnt unchanged, winc=0.
//  Re-arbitration always costs one IDLE cycle. Sustained rate is MAX_BURST words per MAX_BURST+1 cycles.
//  Fairness: rr_ptr advances only on grant. A lone requester is re-granted after each IDLE cycle.
//  winc is never asserted while wFull=1, so the FIFO cannot overflow.
//  No winc is generated in IDLE. req_data of non-granted requesters is ignored.
//  A requester may drop valid mid-burst; the grant is released and its remaining burst quota is forfeited.
//  Reset asserted mid-burst: the transfer is aborted immediately and no partial state is retained.
//   A word is written only if its xfer edge completed before reset.
//  wFull rising and valid falling in the same cycle: release takes priority (go to IDLE).
// CONFIGURATION
//  FIFO_WARB_STATS_EN defined: adds output port stall_cnt [15:0] (registered, reset 0).
//   Increments each cycle with state==GRANT & req_valid[grant_id] & wFull.
//   Saturates at 16'hFFFF; cleared only by reset.
//  Not defined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then req_valid=4'b0001 with data 12'h0A0..: grant_id=0 after 1 IDLE cycle; 4 winc pulses, 1 idle, repeat.
//  2. All 4 valid continuously, wFull=0: grant order 0,1,2,3,0; each gets 4 words; exactly 1 dead cycle between grants.
//  3. Req1 granted, wFull=1 for 5 cycles after the 2nd word: winc=0 and req_ready=0 during stall; grant held;
//     2 remaining words written after wFull falls (stall_cnt=5 with FIFO_WARB_STATS_EN).
//  4. Req2 drops valid after 1 word with req3 valid: IDLE next cycle, then grant_id=3; req2 is not re-granted until its turn.
//  5. wrst low mid-burst (grant_id=1, burst_cnt=2): outputs go to reset values asynchronously;
//     after release, req0 is granted first.
//  6. MAX_BURST=1, NUM_REQ=2, both valid: alternating grants 0,1,0,1; one word each, every 2 cycles.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one ASYNC_FIFO write port among NUM_REQ wclk-domain producers.
// Optional FIFO_WARB_STATS_EN adds a saturating stall_cnt output counting wFull stall cycles.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 12,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                           wclk,
  input  logic                           wrst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           winc,
  output logic [DATA_SIZE-1:0]           wData,
  input  logic                           wFull,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy
`ifdef FIFO_WARB_STATS_EN
  ,
  output logic [15:0]                    stall_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state;
  logic [IDW-1:0]         rr_ptr;
  logic [CW-1:0]          burst_cnt;
  logic [IDW-1:0]         sel;
  logic [IDW-1:0]         cand;
  logic                   found;
  logic                   in_grant;
  logic                   cur_valid;
  logic                   xfer;
  logic [DATA_SIZE-1:0]   data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
  end

  // First valid requester strictly after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    sel   = rr_ptr;
    cand  = rr_ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign in_grant  = (state == GRANT);
  assign cur_valid = req_valid[grant_id];
  assign xfer      = in_grant & cur_valid & ~wFull;
  assign winc      = xfer;
  assign wData     = in_grant ? data_arr[grant_id] : '0;

  always_comb begin
    req_ready = '0;
    if (in_grant) req_ready[grant_id] = ~wFull;
  end

  // Grant FSM; a dropped valid releases before a stall is considered
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NUM_REQ - 1);
      burst_cnt <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state     <= GRANT;
            busy      <= 1'b1;
            grant_id  <= sel;
            rr_ptr    <= sel;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (!cur_valid) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (xfer) begin
            if (burst_cnt == CW'(MAX_BURST - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WARB_STATS_EN
  // Cycles the granted producer had data but the FIFO was full
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      stall_cnt <= '0;
    end else if (in_grant && cur_valid && wFull && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
